// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the public-key decoder state encoding.
package kyber_pkg;

    localparam int unsigned KYBER_N   = 256;
    localparam int unsigned KYBER_Q   = 3329;
    localparam int unsigned COEF_W    = 12;
    localparam int unsigned RHO_W     = 256;
    localparam int unsigned POLY_BITS = KYBER_N * COEF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RHO  = 2'd1,
        COEF = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/pk_unpack_stream_gearbox.sv
// Width converter: packs IN_W-bit beats into a small buffer and drains OUT_W-bit words from the bottom.
module pk_gearbox #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready_c,
    output logic [OUT_W-1:0] out_data_c,
    output logic             out_valid_c,
    input  logic             pop
);

    localparam int unsigned BUF_W = IN_W + OUT_W;
    localparam int unsigned CNT_W = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;

    // Ready depends only on the registered fill level, so a same-cycle pop never widens the window.
    assign in_ready_c  = en && (cnt_q <= CNT_W'(BUF_W - IN_W));
    assign out_valid_c = (cnt_q >= CNT_W'(OUT_W));
    assign out_data_c  = buf_q[OUT_W-1:0];
    assign push        = in_ready_c && in_valid;

    // Bits above cnt are always zero, so an append is a plain OR after the pop shift.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (pop) begin
            buf_d = buf_q >> OUT_W;
            cnt_d = cnt_q - CNT_W'(OUT_W);
        end
        if (push) begin
            buf_d = buf_d | (BUF_W'(in_data) << cnt_d);
            cnt_d = cnt_d + CNT_W'(IN_W);
        end
        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pk_unpack_stream.sv
// Kyber encapsulation-key decoder: captures rho, then streams range-checked t coefficients.
module pk_unpack_stream
    import kyber_pkg::*;
#(
    parameter int unsigned K    = 3,
    parameter int unsigned IN_W = 64,
    parameter int unsigned Q    = 3329
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RHO_W-1:0]  rho,
    output logic              rho_valid,
    output logic [COEF_W-1:0] coef_data,
    output logic [1:0]        coef_poly,
    output logic [7:0]        coef_idx,
    output logic              coef_last,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              busy,
    output logic              done,
    output logic [9:0]        bad_cnt,
    output logic              pk_invalid
);

    localparam int unsigned RHO_BEATS = RHO_W / IN_W;
    localparam int unsigned T_BEATS   = K * POLY_BITS / IN_W;
    localparam int unsigned RB_W      = $clog2(RHO_BEATS + 1);
    localparam int unsigned TB_W      = $clog2(T_BEATS + 1);

    state_e            state_q, state_d;
    logic [RHO_W-1:0]  rho_q, rho_d;
    logic              rho_valid_q, rho_valid_d;
    logic [RB_W-1:0]   rho_beat_q, rho_beat_d;
    logic [TB_W-1:0]   beats_left_q, beats_left_d;
    logic [1:0]        poly_q, poly_d;
    logic [7:0]        idx_q, idx_d;
    logic [9:0]        bad_cnt_q, bad_cnt_d;

    logic              gb_clr, gb_en, gb_ready, gb_valid, pop, accept;
    logic [COEF_W-1:0] gb_data;

    assign gb_clr = (state_q == IDLE) && start;
    assign gb_en  = (state_q == COEF) && (beats_left_q != '0);

    pk_gearbox #(
        .IN_W  (IN_W),
        .OUT_W (COEF_W)
    ) u_gb (
        .clk         (clk),
        .rst         (rst),
        .clr         (gb_clr),
        .en          (gb_en),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready_c  (gb_ready),
        .out_data_c  (gb_data),
        .out_valid_c (gb_valid),
        .pop         (pop)
    );

    assign in_ready   = (state_q == RHO) || gb_ready;
    assign accept     = in_valid && in_ready;
    assign coef_valid = (state_q == COEF) && gb_valid;
    assign coef_data  = gb_data;
    assign coef_poly  = poly_q;
    assign coef_idx   = idx_q;
    assign coef_last  = (poly_q == 2'(K - 1)) && (idx_q == 8'(KYBER_N - 1));
    assign pop        = coef_valid && coef_ready;
    assign rho        = rho_q;
    assign rho_valid  = rho_valid_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign bad_cnt    = bad_cnt_q;
    assign pk_invalid = (bad_cnt_q != '0);

    always_comb begin
        state_d      = state_q;
        rho_d        = rho_q;
        rho_valid_d  = rho_valid_q;
        rho_beat_d   = rho_beat_q;
        beats_left_d = beats_left_q;
        poly_d       = poly_q;
        idx_d        = idx_q;
        bad_cnt_d    = bad_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RHO;
                    rho_d        = '0;
                    rho_valid_d  = 1'b0;
                    rho_beat_d   = '0;
                    beats_left_d = TB_W'(T_BEATS);
                    poly_d       = '0;
                    idx_d        = '0;
                    bad_cnt_d    = '0;
                end
            end
            RHO: begin
                // Shift-in from the top: after all beats, beat 0 sits at rho[IN_W-1:0].
                if (in_valid) begin
                    rho_d      = {in_data, rho_q[RHO_W-1:IN_W]};
                    rho_beat_d = rho_beat_q + RB_W'(1);
                    if (rho_beat_q == RB_W'(RHO_BEATS - 1)) begin
                        rho_valid_d = 1'b1;
                        state_d     = COEF;
                    end
                end
            end
            COEF: begin
                if (accept) begin
                    beats_left_d = beats_left_q - TB_W'(1);
                end
                if (pop) begin
                    if ((32'(coef_data) >= Q) && (bad_cnt_q != '1)) begin
                        bad_cnt_d = bad_cnt_q + 10'd1;
                    end
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'(KYBER_N - 1)) begin
                        poly_d = poly_q + 2'd1;
                    end
                    if (coef_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rho_q        <= '0;
            rho_valid_q  <= 1'b0;
            rho_beat_q   <= '0;
            beats_left_q <= '0;
            poly_q       <= '0;
            idx_q        <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            rho_q        <= rho_d;
            rho_valid_q  <= rho_valid_d;
            rho_beat_q   <= rho_beat_d;
            beats_left_q <= beats_left_d;
            poly_q       <= poly_d;
            idx_q        <= idx_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

endmodule

// File: doc/pk_unpack_stream.md
Name: pk_unpack_stream

Overview:
- Streaming, parametrised decoder for the Kyber encapsulation public key.
- Accepts the serialized key as IN_W-bit beats over a valid/ready handshake and captures the 256-bit rho into a register.
- Emits the K*256 12-bit t coefficients one per cycle, tagged with polynomial and coefficient indices, to downstream NTT/matrix logic.
- Adds a per-coefficient modulus check (coef >= Q); the key is flagged invalid if any coefficient fails. Supports K = 2, 3, 4 (512/768/1024).

Parameters:
- K, 3, number of t polynomials; legal values 2, 3, 4.
- IN_W, 64, input beat width in bits; legal values 8, 16, 32, 64.
- Q, 3329, modulus used by the range check.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begins decoding a new key.
- in_data  in  IN_W  key beat, little-endian bit order.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a beat.
- rho  out  256  captured seed.
- rho_valid  out  1  rho is stable; held until the next start.
- coef_data  out  12  coefficient.
- coef_poly  out  2  polynomial index, 0..K-1.
- coef_idx  out  8  coefficient index, 0..255.
- coef_last  out  1  asserted with the final coefficient (poly K-1, idx 255).
- coef_valid  out  1  coefficient valid.
- coef_ready  in  1  downstream accepts the coefficient.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at completion.
- bad_cnt  out  10  count of coefficients >= Q in the current key.
- pk_invalid  out  1  bad_cnt != 0; valid while done is high and held afterwards.

Behaviour:
- Key layout: bits [255:0] are rho. Coefficient j of poly i is bits [256 + i*3072 + 12*j +: 12].
- Beat n carries key bits [n*IN_W +: IN_W].
- Total beats = 256/IN_W + K*3072/IN_W. For K=3, IN_W=64 this is 4 + 144 = 148.
- Reset values: all outputs 0, rho = 0, state IDLE.
- States:
  - IDLE: in_ready=0. On start go to RHO, clear bad_cnt, rho_valid, buffer and counters.
  - RHO: in_ready=1. Each accepted beat writes rho[beat*IN_W +: IN_W]. After 256/IN_W beats, set rho_valid and go to COEF.
  - COEF: gearbox buffer, BUF_W = IN_W+12 bits, with a fill count cnt.
    - in_ready = (beats_left>0) && (cnt <= BUF_W-IN_W), computed from registered cnt with no pop lookahead.
    - coef_valid = (cnt >= 12).
    - coef_data = buf[11:0]. coef_poly, coef_idx and coef_last come from registered counters.
    - A pop removes the low 12 bits. An accept appends at bit position cnt (after the pop shift when both happen in the same cycle).
    - Push and pop in the same cycle are legal: cnt_next = cnt - 12*pop + IN_W*push.
    - On a pop with coef_data >= Q, bad_cnt increments, saturating at 1023.
    - On the pop with coef_last set, go to DONE.
  - DONE: done=1 for one cycle, then IDLE. rho, rho_valid, bad_cnt and pk_invalid are held.
- Latency: the first coefficient is valid the cycle after the beat that brings cnt to 12 or more. Steady state with no backpressure is one coefficient per cycle.
- Handshake rules:
  - coef_* outputs are stable while coef_valid && !coef_ready.
  - in_data is ignored when in_ready=0.
- Boundary conditions:
  - start while busy is ignored.
  - start in DONE is ignored; the block re-arms once in IDLE.
  - Trailing buffer bits cannot exist, because K*3072 is divisible by both IN_W and 12.
  - rst mid-operation returns the block to reset values immediately.
- coef_valid never asserts outside COEF.

Decomposition:
- Package kyber_pkg: KYBER_N=256, KYBER_Q=3329, COEF_W=12, RHO_W=256, and a state enum {IDLE, RHO, COEF, DONE}.
- Sub-module pk_gearbox(IN_W, OUT_W=12): buffer, fill count, push/pop and ready logic.
- The top level holds the FSM, rho register, index counters and range check.

Test Plan:
- K=3, IN_W=64, coefficient (i,j) = i*256+j, coef_ready=1: expect 148 beats accepted, 768 coefficients in order, each coef_data equal to poly*256+idx, rho = 0x0123..EF pattern, coef_last on (2,255), done one cycle later, bad_cnt=0.
- Same stream with poly 1 idx 5 = 0xFFF and poly 2 idx 255 = 3329: bad_cnt=2 and pk_invalid=1 at done. Coefficient 3328 alone must not count.
- coef_ready asserted every third cycle and in_valid random 50%: output sequence identical to the first scenario, cnt never exceeds 76, no beat is lost.
- K=2, IN_W=8: 32 rho beats and 768 t beats give 512 coefficients; coef_last on (1,255).
- rst asserted at coefficient 300, then start: all outputs return to 0. A fresh key decodes correctly, and rho_valid is 0 until the new rho is complete.
- start pulses during RHO and COEF are ignored. A second start after done decodes a new key, and bad_cnt is cleared to 0.
